branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit counters; fetch prediction has 1-cycle latency.
// fetch_stall holds the registered prediction; a mispredicting resolve flushes it.
module branch_predictor #(
   parameter int PC_W  = 32,
   parameter int IDX_W = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            fetch_valid,
   input  logic [PC_W-1:0] fetch_pc,
   input  logic            fetch_stall,
   output logic            pred_valid,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_dst,
   input  logic            res_valid,
   input  logic [PC_W-1:0] res_src,
   input  logic [PC_W-1:0] res_dst,
   input  logic            res_taken,
   output logic            res_right
);

   localparam int N     = 1 << IDX_W;
   localparam int TAG_W = PC_W - IDX_W - 2;

   logic             btb_vld [N];
   logic [TAG_W-1:0] btb_tag [N];
   logic [PC_W-1:0]  btb_tgt [N];
   logic [1:0]       btb_ctr [N];

   logic [IDX_W-1:0] f_idx, r_idx;
   logic [TAG_W-1:0] f_tag, r_tag;
   logic             f_hit, f_taken, r_hit;
   logic [PC_W-1:0]  f_dst;
   logic [1:0]       r_ctr;
   logic [1:0]       unused_res_lsb;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[PC_W-1:IDX_W+2];
   assign r_idx = res_src[IDX_W+1:2];
   assign r_tag = res_src[PC_W-1:IDX_W+2];
   assign unused_res_lsb = res_src[1:0];

   // Both lookups read pre-update state; same-cycle updates are not bypassed.
   assign f_hit   = btb_vld[f_idx] && (btb_tag[f_idx] == f_tag);
   assign f_taken = f_hit && btb_ctr[f_idx][1];
   assign f_dst   = f_taken ? btb_tgt[f_idx] : fetch_pc + PC_W'(4);

   assign r_hit = btb_vld[r_idx] && (btb_tag[r_idx] == r_tag);
   assign r_ctr = btb_ctr[r_idx];

   always_comb begin
      res_right = 1'b1;
      if (res_valid) begin
         if (r_hit)
            res_right = (r_ctr[1] == res_taken) && (!res_taken || (btb_tgt[r_idx] == res_dst));
         else
            res_right = !res_taken;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            btb_vld[i] <= 1'b0;
            btb_tag[i] <= '0;
            btb_tgt[i] <= '0;
            btb_ctr[i] <= 2'd0;
         end
      end else if (res_valid) begin
         if (r_hit) begin
            if (res_taken) begin
               btb_ctr[r_idx] <= (r_ctr == 2'd3) ? 2'd3 : r_ctr + 2'd1;
               btb_tgt[r_idx] <= res_dst;
            end else begin
               btb_ctr[r_idx] <= (r_ctr == 2'd0) ? 2'd0 : r_ctr - 2'd1;
            end
         end else if (res_taken) begin
            btb_vld[r_idx] <= 1'b1;
            btb_tag[r_idx] <= r_tag;
            btb_tgt[r_idx] <= res_dst;
            btb_ctr[r_idx] <= 2'd2;
         end
      end
   end

   // A mispredict flush outranks both stall and a new fetch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_dst   <= '0;
      end else if (res_valid && !res_right) begin
         pred_valid <= 1'b0;
      end else if (!fetch_stall) begin
         pred_valid <= fetch_valid;
         if (fetch_valid) begin
            pred_taken <= f_taken;
            pred_dst   <= f_dst;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (PC_W=32, IDX_W=4).
module tb_branch_predictor;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_pc = '0;
   logic        fetch_stall = 1'b0;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_dst;
   logic        res_valid = 1'b0;
   logic [31:0] res_src = '0;
   logic [31:0] res_dst = '0;
   logic        res_taken = 1'b0;
   logic        res_right;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.PC_W(32), .IDX_W(4)) dut (
      .clock(clock), .reset(reset),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_dst(pred_dst),
      .res_valid(res_valid), .res_src(res_src), .res_dst(res_dst),
      .res_taken(res_taken), .res_right(res_right)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic resolve(input logic [31:0] src, input logic [31:0] dst, input logic tk);
      res_valid = 1'b1;
      res_src   = src;
      res_dst   = dst;
      res_taken = tk;
      #1;
   endtask

   task automatic check_pred(input string tag, input logic v, input logic tk, input logic [31:0] dst);
      check({tag, "_valid"}, 32'(pred_valid), 32'(v));
      check({tag, "_taken"}, 32'(pred_taken), 32'(tk));
      check({tag, "_dst"}, pred_dst, dst);
   endtask

   initial begin
      logic [2:0] exp_nt;
      logic [2:0] exp_tk;
      logic [31:0] stall_pc [3];
      exp_nt = 3'b110;  // bit i = expected res_right of step i
      exp_tk = 3'b100;
      stall_pc[0] = 32'h100;
      stall_pc[1] = 32'h200;
      stall_pc[2] = 32'h300;

      tick;
      tick;
      check_pred("reset", 1'b0, 1'b0, 32'h0);
      check("reset_res_right", 32'(res_right), 32'd1);
      reset = 1'b0;

      // cold fetch predicts fall-through
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100;
      tick;
      check_pred("cold_fetch", 1'b1, 1'b0, 32'h104);

      // allocate on taken miss; flush overrides a live fetch
      resolve(32'h100, 32'h200, 1'b1);
      check("alloc_res_right", 32'(res_right), 32'd0);
      tick;
      check("flush_valid", 32'(pred_valid), 32'd0);
      res_valid = 1'b0;
      tick;
      check_pred("after_alloc", 1'b1, 1'b1, 32'h200);

      // counter 2 -> 1 -> 0 -> 0
      fetch_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         resolve(32'h100, 32'h0, 1'b0);
         check($sformatf("nt_res_right%0d", i), 32'(res_right), 32'(exp_nt[i]));
         tick;
      end
      res_valid   = 1'b0;
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100;
      tick;
      check_pred("after_nt", 1'b1, 1'b0, 32'h104);
      fetch_valid = 1'b0;
      tick;
      check("idle_clears_valid", 32'(pred_valid), 32'd0);

      // counter 0 -> 1 -> 2 -> 3, then wrong target at counter 3
      for (int i = 0; i < 3; i++) begin
         resolve(32'h100, 32'h200, 1'b1);
         check($sformatf("tk_res_right%0d", i), 32'(res_right), 32'(exp_tk[i]));
         tick;
      end
      resolve(32'h100, 32'h300, 1'b1);
      check("wrong_tgt_res_right", 32'(res_right), 32'd0);
      tick;
      res_valid   = 1'b0;
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100;
      tick;
      check_pred("new_tgt", 1'b1, 1'b1, 32'h300);

      // alias 0x140 evicts 0x100
      resolve(32'h140, 32'h500, 1'b1);
      fetch_valid = 1'b0;
      check("alias_res_right", 32'(res_right), 32'd0);
      tick;
      resolve(32'h100, 32'h0, 1'b0);
      check("evicted_nt_res_right", 32'(res_right), 32'd1);
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100;
      tick;
      res_valid = 1'b0;
      check_pred("evicted", 1'b1, 1'b0, 32'h104);
      fetch_pc = 32'hFFFF_FFFC;
      tick;
      check_pred("wrap", 1'b1, 1'b0, 32'h0);
      fetch_pc = 32'h140;
      tick;
      check_pred("alias_hit", 1'b1, 1'b1, 32'h500);

      // stall holds outputs while fetch_pc moves
      fetch_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_pc = stall_pc[i];
         tick;
         check_pred($sformatf("stall%0d", i), 1'b1, 1'b1, 32'h500);
      end
      #2;
      reset = 1'b1;
      #1;
      check_pred("async_reset", 1'b0, 1'b0, 32'h0);
      @(negedge clock);
      reset       = 1'b0;
      fetch_stall = 1'b0;
      fetch_pc    = 32'h140;
      tick;
      check_pred("post_reset", 1'b1, 1'b0, 32'h144);
      resolve(32'h140, 32'h500, 1'b1);
      check("post_reset_res_right", 32'(res_right), 32'd0);
      res_valid = 1'b0;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
